// File: rtl/uart_buf_pkg.sv
// uart_buf_pkg: shared ring geometry, ring-select defaults and arbiter grant encoding
package uart_buf_pkg;
  localparam int DEPTH_LOG2 = 8;
  localparam logic RX_SEL_DEFAULT = 1'b0;
  typedef enum logic [1:0] {GNT_NONE = 2'd0, GNT_USER = 2'd1, GNT_PEER = 2'd2} gnt_e;
  function automatic logic tx_sel(input logic rx_base);
    return ~rx_base;
  endfunction
endpackage

// File: rtl/uart_buffer_ctrl_if.sv
// uart_buffer_ctrl_if: RAM ports, the four ring handshakes and status of the buffer controller
interface uart_buffer_ctrl_if #(parameter int DEPTH_LOG2 = uart_buf_pkg::DEPTH_LOG2);
  localparam int AW = DEPTH_LOG2 + 1;
  logic [AW-1:0] ram_r_addr;
  logic [7:0]    ram_r_data;
  logic [AW-1:0] ram_w_addr;
  logic [7:0]    ram_w_data;
  logic          ram_we;
  logic          user_rd_req, user_rd_ack;
  logic [7:0]    user_rd_data;
  logic          user_wr_req, user_wr_ack;
  logic [7:0]    user_wr_data;
  logic          tx_rd_req, tx_rd_ack;
  logic [7:0]    tx_rd_data;
  logic          rx_wr_req, rx_wr_ack;
  logic [7:0]    rx_wr_data;
  logic [AW-1:0] rx_count, tx_count;
  logic          rx_overflow, clr_overflow;
  modport master (
    output ram_r_data, user_rd_req, user_wr_req, user_wr_data, tx_rd_req, rx_wr_req, rx_wr_data, clr_overflow,
    input  ram_r_addr, ram_w_addr, ram_w_data, ram_we, user_rd_ack, user_rd_data, user_wr_ack,
           tx_rd_ack, tx_rd_data, rx_wr_ack, rx_count, tx_count, rx_overflow
  );
  modport slave (
    input  ram_r_data, user_rd_req, user_wr_req, user_wr_data, tx_rd_req, rx_wr_req, rx_wr_data, clr_overflow,
    output ram_r_addr, ram_w_addr, ram_w_data, ram_we, user_rd_ack, user_rd_data, user_wr_ack,
           tx_rd_ack, tx_rd_data, rx_wr_ack, rx_count, tx_count, rx_overflow
  );
endinterface

// File: rtl/uart_rr_arb2.sv
// uart_rr_arb2: two-requester round-robin arbiter that idles one cycle after every grant
module uart_rr_arb2
  import uart_buf_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output gnt_e       gnt
);
  logic busy;
  gnt_e last;
  always_comb
    gnt = busy ? GNT_NONE
        : &req ? (last == GNT_USER ? GNT_PEER : GNT_USER)
        : req[0] ? GNT_USER
        : req[1] ? GNT_PEER : GNT_NONE;
  // history starts as "peer served" so the user side wins the first contest
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      busy <= 1'b0;
      last <= GNT_PEER;
    end else begin
      busy <= gnt != GNT_NONE;
      if (gnt != GNT_NONE) last <= gnt;
    end
endmodule

// File: rtl/uart_buffer_ctrl.sv
// uart_buffer_ctrl: RX and TX byte rings sharing one dual-port RAM, one arbiter per RAM port
module uart_buffer_ctrl
  import uart_buf_pkg::*;
#(
  parameter int   DEPTH_LOG2 = uart_buf_pkg::DEPTH_LOG2,
  parameter logic RX_BASE    = RX_SEL_DEFAULT
) (
  input logic               clk,
  input logic               rst,
  uart_buffer_ctrl_if.slave bus
);
  localparam int CW = DEPTH_LOG2 + 1;
  localparam logic [CW-1:0] FULL = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic TX_BASE = tx_sel(RX_BASE);
  logic [DEPTH_LOG2-1:0] rx_wr_ptr, rx_rd_ptr, tx_wr_ptr, tx_rd_ptr;
  logic [CW-1:0] rx_count, tx_count;
  gnt_e rd_gnt, wr_gnt, rd_pend;
  logic rx_full, user_pop, tx_pop, user_push, rx_push, rx_store;
  // a requester whose ack is showing is finishing, not asking again
  uart_rr_arb2 u_rd_arb (
    .clk(clk),
    .rst(rst),
    .req({bus.tx_rd_req & ~bus.tx_rd_ack & (tx_count != '0),
          bus.user_rd_req & ~bus.user_rd_ack & (rx_count != '0)}),
    .gnt(rd_gnt)
  );
  uart_rr_arb2 u_wr_arb (
    .clk(clk),
    .rst(rst),
    .req({bus.rx_wr_req & ~bus.rx_wr_ack,
          bus.user_wr_req & ~bus.user_wr_ack & (tx_count != FULL)}),
    .gnt(wr_gnt)
  );
  assign rx_full   = rx_count == FULL;
  assign user_pop  = rd_gnt == GNT_USER;
  assign tx_pop    = rd_gnt == GNT_PEER;
  assign user_push = wr_gnt == GNT_USER;
  assign rx_push   = wr_gnt == GNT_PEER;
  assign rx_store  = rx_push & ~rx_full;
  assign bus.rx_count = rx_count;
  assign bus.tx_count = tx_count;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rx_wr_ptr        <= '0;
      rx_rd_ptr        <= '0;
      tx_wr_ptr        <= '0;
      tx_rd_ptr        <= '0;
      rx_count         <= '0;
      tx_count         <= '0;
      rd_pend          <= GNT_NONE;
      bus.ram_r_addr   <= '0;
      bus.ram_w_addr   <= '0;
      bus.ram_w_data   <= '0;
      bus.ram_we       <= 1'b0;
      bus.user_rd_ack  <= 1'b0;
      bus.user_rd_data <= '0;
      bus.tx_rd_ack    <= 1'b0;
      bus.tx_rd_data   <= '0;
      bus.user_wr_ack  <= 1'b0;
      bus.rx_wr_ack    <= 1'b0;
      bus.rx_overflow  <= 1'b0;
    end else begin
      rd_pend         <= rd_gnt;
      bus.user_rd_ack <= rd_pend == GNT_USER;
      bus.tx_rd_ack   <= rd_pend == GNT_PEER;
      if (rd_pend == GNT_USER) bus.user_rd_data <= bus.ram_r_data;
      if (rd_pend == GNT_PEER) bus.tx_rd_data <= bus.ram_r_data;
      if (user_pop) begin
        bus.ram_r_addr <= {RX_BASE, rx_rd_ptr};
        rx_rd_ptr      <= rx_rd_ptr + DEPTH_LOG2'(1);
      end
      if (tx_pop) begin
        bus.ram_r_addr <= {TX_BASE, tx_rd_ptr};
        tx_rd_ptr      <= tx_rd_ptr + DEPTH_LOG2'(1);
      end
      bus.ram_we      <= user_push | rx_store;
      bus.user_wr_ack <= user_push;
      bus.rx_wr_ack   <= rx_push;
      if (user_push) begin
        bus.ram_w_addr <= {TX_BASE, tx_wr_ptr};
        bus.ram_w_data <= bus.user_wr_data;
        tx_wr_ptr      <= tx_wr_ptr + DEPTH_LOG2'(1);
      end
      if (rx_store) begin
        bus.ram_w_addr <= {RX_BASE, rx_wr_ptr};
        bus.ram_w_data <= bus.rx_wr_data;
        rx_wr_ptr      <= rx_wr_ptr + DEPTH_LOG2'(1);
      end
      rx_count        <= rx_count + CW'(rx_store) - CW'(user_pop);
      tx_count        <= tx_count + CW'(user_push) - CW'(tx_pop);
      bus.rx_overflow <= (rx_push & rx_full) | (bus.rx_overflow & ~bus.clr_overflow);
    end
endmodule
